chu_vga_platform_core: RTL and testbench

Procedural platform renderer for the Doodle Jump video pipeline, occupying daisy-chain slot V4_USER4. It sits between the doodle sprite core (upstream, drives si_rgb) and the ghost sprite core (downstream, consumes so_rgb). The core draws up to 8 double-buffered 64x16 platforms over the incoming pixel stream. It also runs a hardware sink-and-vanish animation for breaking platforms.

---
 rtl/chu_vga_platform_core.sv | 173 +++++++++++++++++
 tb/tb_chu_vga_platform_core.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chu_vga_platform_core.sv
// Procedural platform renderer: up to 8 double-buffered platforms drawn over the
// incoming pixel stream, with a per-frame sink-and-vanish animation for breaking ones.
module chu_vga_platform_core #(
  parameter int CD = 12,
  parameter int PW = 64,
  parameter int PH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  localparam logic [10:0] PW_M1 = 11'(PW - 1);
  localparam logic [10:0] PH_M1 = 11'(PH - 1);

  // Platform word layout: [9:0] px, [19:10] py, [21:20] type.
  logic [21:0]   shadow_q [8];
  logic [21:0]   shadow_d [8];
  logic [21:0]   active_q [8];
  logic [21:0]   active_d [8];
  logic [3:0]    sc_q     [8];
  logic [3:0]    sc_d     [8];
  logic [7:0]    sink_q, sink_d;
  logic          en_q, en_d;
  logic          pend_q, pend_d;
  logic          at00_q;
  logic          hit_q, hit_d;
  logic [CD-1:0] col_q, col_d;
  logic [CD-1:0] si_d1_q;
  logic [CD-1:0] so_q;

  logic          at00, tick, we, brk_ok;
  logic [2:0]    brk_idx;
  logic [10:0]   left_w [8];
  logic [10:0]   top_w  [8];
  logic [10:0]   u_w    [8];
  logic [10:0]   v_w    [8];
  logic [7:0]    on_w, border_w;
  logic          unused_w;

  assign unused_w = ^{addr[13:4], wr_data[31:22]};

  function automatic logic [CD-1:0] palette(input logic [1:0] ty, input logic border);
    case (ty)
      2'd1:    return border ? 12'h050 : 12'h0A0;
      2'd2:    return border ? 12'h035 : 12'h08F;
      2'd3:    return border ? 12'h420 : 12'h852;
      default: return '0;
    endcase
  endfunction

  assign at00    = (x == 11'd0) && (y == 11'd0);
  assign tick    = at00 && !at00_q;
  assign we      = cs && write;
  assign brk_idx = wr_data[2:0];
  assign brk_ok  = we && (addr[3:0] == 4'd9) && (active_q[brk_idx][21:20] == 2'd3)
                   && !sink_q[brk_idx];

  // Per-platform hit and shape classification against the active set.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      left_w[i]   = {1'b0, active_q[i][9:0]};
      top_w[i]    = {1'b0, active_q[i][19:10]} + {6'd0, sc_q[i], 1'b0};
      u_w[i]      = x - left_w[i];
      v_w[i]      = y - top_w[i];
      border_w[i] = (u_w[i] == 11'd0) || (u_w[i] == PW_M1) ||
                    (v_w[i] == 11'd0) || (v_w[i] == PH_M1);
      on_w[i]     = (active_q[i][21:20] != 2'd0) &&
                    (x >= left_w[i]) && (x <= left_w[i] + PW_M1) &&
                    (y >= top_w[i])  && (y <= top_w[i] + PH_M1) &&
                    !(((u_w[i] == 11'd0) || (u_w[i] == PW_M1)) &&
                      ((v_w[i] == 11'd0) || (v_w[i] == PH_M1)));
    end
  end

  // Walk from the highest index down so the lowest hitting index is left standing.
  always_comb begin
    hit_d = 1'b0;
    col_d = '0;
    for (int i = 7; i >= 0; i--) begin
      if (en_q && on_w[i]) begin
        hit_d = 1'b1;
        col_d = palette(active_q[i][21:20], border_w[i]);
      end
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    sc_d     = sc_q;
    sink_d   = sink_q;
    en_d     = en_q;
    pend_d   = pend_q;

    if (tick && pend_q) begin
      active_d = shadow_q;
      sink_d   = '0;
      pend_d   = 1'b0;
      for (int i = 0; i < 8; i++) sc_d[i] = 4'd0;
    end else begin
      if (tick) begin
        for (int i = 0; i < 8; i++) begin
          if (sink_q[i]) begin
            if (sc_q[i] == 4'd15) begin
              active_d[i][21:20] = 2'd0;
              sink_d[i]          = 1'b0;
              sc_d[i]            = 4'd0;
            end else begin
              sc_d[i] = sc_q[i] + 4'd1;
            end
          end
        end
      end
      // A break landing on a tick restarts the animation without advancing it.
      if (brk_ok) begin
        sink_d[brk_idx] = 1'b1;
        sc_d[brk_idx]   = 4'd0;
      end
    end

    if (we) begin
      if (addr[3] == 1'b0) begin
        shadow_d[addr[2:0]] = wr_data[21:0];
      end else if (addr[3:0] == 4'd8) begin
        en_d = wr_data[0];
        if (wr_data[1]) pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        sc_q[i]     <= '0;
      end
      sink_q  <= '0;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      at00_q  <= 1'b0;
      hit_q   <= 1'b0;
      col_q   <= '0;
      si_d1_q <= '0;
      so_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      sc_q     <= sc_d;
      sink_q   <= sink_d;
      en_q     <= en_d;
      pend_q   <= pend_d;
      at00_q   <= at00;
      // Stage 1: hit, colour and the upstream pixel captured together.
      hit_q    <= hit_d;
      col_q    <= col_d;
      si_d1_q  <= si_rgb;
      // Stage 2: final mux.
      so_q     <= hit_q ? col_q : si_d1_q;
    end
  end

  assign so_rgb = so_q;

endmodule

// File: tb/tb_chu_vga_platform_core.sv
// Directed bench for chu_vga_platform_core: a frame-level model predicts every output
// pixel, and hand-computed colours at chosen coordinates pin that model down.
module tb_chu_vga_platform_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y;
  logic        cs, write;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [11:0] si_rgb, so_rgb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chu_vga_platform_core #(.CD(12), .PW(64), .PH(16)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .write(write),
    .addr(addr), .wr_data(wr_data), .si_rgb(si_rgb), .so_rgb(so_rgb)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_spx[8], m_spy[8], m_sty[8];
  int m_px[8], m_py[8], m_ty[8], m_sc[8];
  bit m_sink[8];
  bit m_en, m_pend, m_prev;
  int col_h[8192], si_h[8192];
  bit rst_h[8192];
  int ncyc = 0;

  function automatic int colour_of(int ty, bit border);
    case (ty)
      1: return border ? 'h050 : 'h0A0;
      2: return border ? 'h035 : 'h08F;
      3: return border ? 'h420 : 'h852;
      default: return 0;
    endcase
  endfunction

  // What the screen shows at (xx,yy) for the current model state; -1 means pass-through.
  function automatic int render(int xx, int yy);
    int top, u, v;
    if (!m_en) return -1;
    for (int i = 0; i < 8; i++) begin
      if (m_ty[i] == 0) continue;
      top = m_py[i] + 2 * m_sc[i];
      if (xx < m_px[i] || xx > m_px[i] + 63 || yy < top || yy > top + 15) continue;
      u = xx - m_px[i];
      v = yy - top;
      if ((u == 0 || u == 63) && (v == 0 || v == 15)) continue;
      return colour_of(m_ty[i], (u == 0 || u == 63 || v == 0 || v == 15));
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int n, a, bi;
    bit at00, tk, wen, brk;
    n = ncyc % 8192;
    rst_h[n] = reset;
    si_h[n]  = si_rgb;
    col_h[n] = reset ? -1 : render(x, y);
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_spx[i] = 0; m_spy[i] = 0; m_sty[i] = 0;
        m_px[i] = 0; m_py[i] = 0; m_ty[i] = 0; m_sc[i] = 0; m_sink[i] = 0;
      end
      m_en = 0; m_pend = 0; m_prev = 0;
    end else begin
      at00 = (x == 0) && (y == 0);
      tk = at00 && !m_prev;
      m_prev = at00;
      wen = cs && write;
      a = addr[3:0];
      bi = wr_data[2:0];
      brk = wen && a == 9 && m_ty[bi] == 3 && !m_sink[bi];
      if (tk && m_pend) begin
        for (int i = 0; i < 8; i++) begin
          m_px[i] = m_spx[i]; m_py[i] = m_spy[i]; m_ty[i] = m_sty[i];
          m_sink[i] = 0; m_sc[i] = 0;
        end
        m_pend = 0;
      end else begin
        if (tk) begin
          for (int i = 0; i < 8; i++) begin
            if (m_sink[i]) begin
              if (m_sc[i] == 15) begin m_ty[i] = 0; m_sink[i] = 0; m_sc[i] = 0; end
              else m_sc[i] = m_sc[i] + 1;
            end
          end
        end
        if (brk) begin m_sink[bi] = 1; m_sc[bi] = 0; end
      end
      if (wen && a < 8) begin
        m_spx[a] = wr_data[9:0]; m_spy[a] = wr_data[19:10]; m_sty[a] = wr_data[21:20];
      end else if (wen && a == 8) begin
        m_en = wr_data[0];
        if (wr_data[1]) m_pend = 1;
      end
    end
    ncyc++;
  end

  // so_rgb after edge n reflects the sample taken at edge n-1.
  always @(negedge clk) begin
    int l, p, exp;
    if (ncyc >= 2) begin
      l = (ncyc - 1) % 8192;
      p = (ncyc - 2) % 8192;
      if (rst_h[l] || rst_h[p]) exp = 0;
      else exp = (col_h[p] >= 0) ? col_h[p] : si_h[p];
      check("model", so_rgb, exp);
    end
  end

  // ---------------- stimulus ----------------
  function automatic int plat(int px, int py, int ty);
    return (ty << 20) | (py << 10) | px;
  endfunction

  task automatic wr(input int a, input int d);
    cs = 1; write = 1; addr = 14'(a); wr_data = d;
    @(negedge clk);
    cs = 0; write = 0; addr = '0; wr_data = '0;
  endtask

  task automatic tick_frame();
    x = 0; y = 0;
    @(negedge clk);
    x = 1; y = 1;
    @(negedge clk);
  endtask

  task automatic probe(input string name, input int xx, input int yy, input int exp);
    x = 11'(xx); y = 11'(yy);
    @(negedge clk);
    @(negedge clk);
    check(name, so_rgb, exp);
  endtask

  initial begin
    reset = 1; x = 1; y = 1; cs = 0; write = 0; addr = '0; wr_data = '0; si_rgb = 12'h123;
    repeat (3) @(negedge clk);
    check("reset_so", so_rgb, 0);
    reset = 0;
    @(negedge clk);
    check("release_1cyc", so_rgb, 0);
    @(negedge clk);
    check("release_2cyc", so_rgb, 'h123);

    // Single normal platform
    wr(0, plat(100, 200, 1));
    wr(8, 3);
    tick_frame();
    probe("p0_fill", 132, 208, 'h0A0);
    probe("p0_border", 100, 208, 'h050);
    probe("p0_corner", 100, 200, 'h123);
    probe("p0_right_out", 164, 208, 'h123);
    probe("p0_bottom", 130, 215, 'h050);
    probe("p0_above", 130, 199, 'h123);
    x = 132; y = 208;
    @(negedge clk);
    check("latency_1cyc", so_rgb, 'h123);
    @(negedge clk);
    check("latency_2cyc", so_rgb, 'h0A0);

    // Overlap priority; shadow 1 written through an alias with upper address bits set
    wr(0, plat(50, 50, 1));
    wr('h0101, plat(60, 52, 2));
    wr(10, 'h3FFFFF);
    wr(8, 3);
    tick_frame();
    probe("overlap_p0", 80, 58, 'h0A0);
    probe("p0_only", 55, 51, 'h0A0);
    probe("p1_only", 115, 60, 'h08F);
    wr(0, 0);
    wr(8, 3);
    tick_frame();
    probe("overlap_p1", 80, 58, 'h08F);
    wr(8, 0);
    probe("disabled", 80, 58, 'h123);
    wr(8, 1);
    probe("reenabled", 80, 58, 'h08F);

    // Sink animation of breaking platform 3
    wr(3, plat(500, 300, 3));
    wr(8, 3);
    tick_frame();
    probe("brk_top", 532, 300, 'h420);
    probe("brk_fill", 533, 305, 'h852);
    wr(9, 3);
    for (int k = 0; k < 16; k++) begin
      probe($sformatf("sink_top_k%0d", k), 532, 300 + 2 * k, 'h420);
      probe($sformatf("sink_above_k%0d", k), 532, 299 + 2 * k, 'h123);
      tick_frame();
    end
    probe("vanished_low", 532, 330, 'h123);
    probe("vanished_orig", 532, 300, 'h123);
    wr(9, 3);
    tick_frame();
    probe("late_break_ignored", 532, 300, 'h123);
    probe("p1_still", 115, 60, 'h08F);

    // Commit landing on a tick cycle waits for the next tick
    wr(0, plat(200, 100, 1));
    x = 0; y = 0; cs = 1; write = 1; addr = 14'd8; wr_data = 3;
    @(negedge clk);
    cs = 0; write = 0; addr = '0; wr_data = '0; x = 1; y = 1;
    @(negedge clk);
    probe("commit_on_tick_held", 232, 108, 'h123);
    tick_frame();
    probe("commit_next_tick", 232, 108, 'h0A0);
    probe("p3_recommitted", 532, 300, 'h420);

    // Break issued on a tick cycle does not advance that frame
    x = 0; y = 0; cs = 1; write = 1; addr = 14'd9; wr_data = 3;
    @(negedge clk);
    cs = 0; write = 0; addr = '0; wr_data = '0; x = 1; y = 1;
    @(negedge clk);
    probe("brk_on_tick_sc0", 532, 300, 'h420);
    tick_frame();
    probe("brk_on_tick_next", 532, 302, 'h420);
    probe("brk_on_tick_old", 532, 300, 'h123);
    tick_frame();
    tick_frame();
    probe("sink_before_rst", 532, 306, 'h420);

    // Asynchronous reset mid-animation
    x = 532; y = 306;
    @(negedge clk);
    #2 reset = 1;
    #1 check("async_reset_so", so_rgb, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    probe("post_rst_pass", 532, 306, 'h123);
    wr(8, 3);
    tick_frame();
    probe("post_rst_p3_off", 532, 306, 'h123);
    probe("post_rst_p0_off", 232, 108, 'h123);
    probe("post_rst_p1_off", 115, 60, 'h123);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
